// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M multiply/divide unit beside execute.
// Optional MULDIV_WORD_FAST_EN: word ops iterate 32 times instead of 64.
module muldiv_unit #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic              mul_en_i,
  input  logic              rs1_sign_i,
  input  logic              rs2_sign_i,
  input  logic              word_i,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] data_1_o,
  output logic [DATA_W-1:0] data_2_o
);

  localparam int W  = DATA_W;
  localparam int HW = DATA_W / 2;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  opnd_q, opnd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mul_q, mul_d;
  logic          word_q, word_d;
  logic          fw_q, fw_d;
  logic          qneg_q, qneg_d;
  logic          rneg_q, rneg_d;
  logic          dz_q, dz_d;
  logic [W-1:0]  res1_q, res1_d;
  logic [W-1:0]  res2_q, res2_d;

  logic          accept;
  logic          fw_in;
  logic [W-1:0]  a_ext, b_ext;
  logic [W-1:0]  a_sx;
  logic [W-1:0]  a_mag, b_mag;
  logic          a_neg, b_neg;
  logic          b_zero;

`ifdef MULDIV_WORD_FAST_EN
  assign fw_in = word_i;
`else
  assign fw_in = 1'b0;
`endif

  assign accept = req_valid_i & ~flush_i;

  always_comb begin
    a_ext = rs1_data_i;
    b_ext = rs2_data_i;
    if (word_i) begin
      a_ext = {{HW{rs1_sign_i & rs1_data_i[HW-1]}},
               rs1_data_i[HW-1:0]};
      b_ext = {{HW{rs2_sign_i & rs2_data_i[HW-1]}},
               rs2_data_i[HW-1:0]};
    end
    a_sx = word_i ?
      {{HW{rs1_data_i[HW-1]}}, rs1_data_i[HW-1:0]} :
      rs1_data_i;
    a_neg  = rs1_sign_i & a_ext[W-1];
    b_neg  = rs2_sign_i & b_ext[W-1];
    a_mag  = a_neg ? ~a_ext + W'(1) : a_ext;
    b_mag  = b_neg ? ~b_ext + W'(1) : b_ext;
    b_zero = ~|b_ext;
  end

  // One iteration: hi:lo is the product/remainder:dividend pair.
  logic [W:0]   sum;
  logic [W:0]   rsh;
  logic [W:0]   diff;
  logic [W-1:0] it_hi, it_lo;

  always_comb begin
    sum  = {1'b0, hi_q} +
           (lo_q[0] ? {1'b0, opnd_q} : '0);
    rsh  = {hi_q, lo_q[W-1]};
    diff = rsh - {1'b0, opnd_q};
    if (mul_q) begin
      it_hi = sum[W:1];
      it_lo = {sum[0], lo_q[W-1:1]};
    end else begin
      it_hi = diff[W] ? rsh[W-1:0] : diff[W-1:0];
      it_lo = {lo_q[W-2:0], ~diff[W]};
    end
  end

  logic [2*W-1:0] prod, prod_s;
  logic [W-1:0]   quo_s, rem_s;
  logic [W-1:0]   r1, r2;

  always_comb begin
    prod = fw_q ?
      {{W{1'b0}}, hi_q[HW-1:0], lo_q[W-1:HW]} :
      {hi_q, lo_q};
    prod_s = qneg_q ? ~prod + (2*W)'(1) : prod;
    quo_s  = qneg_q ? ~lo_q + W'(1) : lo_q;
    rem_s  = rneg_q ? ~hi_q + W'(1) : hi_q;
    r1 = quo_s;
    r2 = rem_s;
    if (dz_q) begin
      r1 = '1;
      r2 = lo_q;
    end else if (mul_q) begin
      r1 = prod_s[W-1:0];
      r2 = word_q ?
        {{HW{1'b0}}, prod_s[W-1:HW]} :
        prod_s[2*W-1:W];
    end
    if (word_q) begin
      r1 = {{HW{r1[HW-1]}}, r1[HW-1:0]};
      r2 = {{HW{r2[HW-1]}}, r2[HW-1:0]};
    end
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    mul_d   = mul_q;
    word_d  = word_q;
    fw_d    = fw_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    res1_d  = res1_q;
    res2_d  = res2_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          mul_d  = mul_en_i;
          word_d = word_i;
          fw_d   = fw_in;
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          dz_d   = ~mul_en_i & b_zero;
          cnt_d  = fw_in ? CW'(HW-1) : CW'(W-1);
          hi_d   = '0;
          if (mul_en_i) begin
            opnd_d = a_mag;
            lo_d   = b_mag;
          end else begin
            opnd_d = b_mag;
            lo_d   = fw_in ?
              {a_mag[HW-1:0], {HW{1'b0}}} : a_mag;
          end
          if (~mul_en_i & b_zero) begin
            lo_d    = a_sx;
            state_d = S_DONE;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        hi_d  = it_hi;
        lo_d  = it_lo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        res1_d  = r1;
        res2_d  = r2;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A killed instruction leaves no trace on the outputs.
    if (flush_i) begin
      state_d = S_IDLE;
      res1_d  = res1_q;
      res2_d  = res2_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      cnt_q   <= '0;
      mul_q   <= 1'b0;
      word_q  <= 1'b0;
      fw_q    <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      res1_q  <= '0;
      res2_q  <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
      mul_q   <= mul_d;
      word_q  <= word_d;
      fw_q    <= fw_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      res1_q  <= res1_d;
      res2_q  <= res2_d;
    end
  end

  assign busy_o = (state_q == S_BUSY) |
                  ((state_q == S_IDLE) & accept);
  assign resp_valid_o = (state_q == S_DONE) & ~flush_i;
  assign data_1_o = resp_valid_o ? r1 : res1_q;
  assign data_2_o = resp_valid_o ? r2 : res2_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed + random checks of muldiv_unit
// against a wide-integer arithmetic reference.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        mul_en_i = 1'b0;
  logic        rs1_sign_i = 1'b0;
  logic        rs2_sign_i = 1'b0;
  logic        word_i = 1'b0;
  logic [63:0] rs1_data_i = '0;
  logic [63:0] rs2_data_i = '0;
  logic        flush_i = 1'b0;
  logic        busy_o;
  logic        resp_valid_o;
  logic [63:0] data_1_o;
  logic [63:0] data_2_o;

  int checks = 0;
  int failures = 0;

  muldiv_unit #(.DATA_W(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .mul_en_i     (mul_en_i),
    .rs1_sign_i   (rs1_sign_i),
    .rs2_sign_i   (rs2_sign_i),
    .word_i       (word_i),
    .rs1_data_i   (rs1_data_i),
    .rs2_data_i   (rs2_data_i),
    .flush_i      (flush_i),
    .busy_o       (busy_o),
    .resp_valid_o (resp_valid_o),
    .data_1_o     (data_1_o),
    .data_2_o     (data_2_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference: exact signed arithmetic on 130-bit integers.
  function automatic void model(
    input  logic m, s1, s2, w,
    input  logic [63:0] a, b,
    output logic [63:0] e1, e2);
    logic signed [129:0] av, bv, p, q, r;
    if (w) begin
      av = s1 ? {{98{a[31]}}, a[31:0]} : {98'b0, a[31:0]};
      bv = s2 ? {{98{b[31]}}, b[31:0]} : {98'b0, b[31:0]};
    end else begin
      av = s1 ? {{66{a[63]}}, a} : {66'b0, a};
      bv = s2 ? {{66{b[63]}}, b} : {66'b0, b};
    end
    if (m) begin
      p = av * bv;
      e1 = w ? sx32(p[31:0])  : p[63:0];
      e2 = w ? sx32(p[63:32]) : p[127:64];
    end else begin
      if (bv == 0) begin
        q = -130'sd1;
        r = av;
      end else begin
        q = av / bv;
        r = av % bv;
      end
      e1 = w ? sx32(q[31:0]) : q[63:0];
      e2 = w ? sx32(r[31:0]) : r[63:0];
    end
  endfunction

  function automatic int exp_latency(
    input logic m, w, input logic [63:0] b);
    if (!m && (w ? (b[31:0] == 32'd0) : (b == 64'd0)))
      return 1;
`ifdef MULDIV_WORD_FAST_EN
    if (w) return 33;
`endif
    return 65;
  endfunction

  // Called #1 after a rising edge with the DUT idle.
  task automatic run_op(input string tag,
                        input logic m, s1, s2, w,
                        input logic [63:0] a, b);
    logic [63:0] e1, e2;
    int lat;
    bit got;
    model(m, s1, s2, w, a, b, e1, e2);
    lat = exp_latency(m, w, b);
    req_valid_i = 1'b1;
    mul_en_i    = m;
    rs1_sign_i  = s1;
    rs2_sign_i  = s2;
    word_i      = w;
    rs1_data_i  = a;
    rs2_data_i  = b;
    #1;
    check({tag, "/busy_accept"}, 64'(busy_o), 64'd1);
    got = 1'b0;
    for (int c = 1; c <= 100 && !got; c++) begin
      @(posedge clk); #1;
      if (resp_valid_o) begin
        got = 1'b1;
        check({tag, "/latency"}, 64'(c), 64'(lat));
        check({tag, "/busy_done"}, 64'(busy_o), 64'd0);
        check({tag, "/data_1"}, data_1_o, e1);
        check({tag, "/data_2"}, data_2_o, e2);
      end else begin
        check({tag, "/busy_iter"}, 64'(busy_o), 64'd1);
      end
    end
    check({tag, "/resp_seen"}, 64'(got), 64'd1);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    #1;
    check({tag, "/resp_pulse"}, 64'(resp_valid_o), 64'd0);
    check({tag, "/hold_1"}, data_1_o, e1);
    check({tag, "/hold_2"}, data_2_o, e2);
  endtask

  function automatic logic [63:0] pick(input int sel);
    case (sel)
      1: return 64'd0;
      2: return '1;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'h0000_0000_8000_0000;
      5: return 64'($urandom_range(0, 9));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [63:0] p1, p2;
    bit seen;

    repeat (2) @(posedge clk);
    #1;
    check("rst/resp", 64'(resp_valid_o), 64'd0);
    check("rst/data_1", data_1_o, 64'd0);
    check("rst/data_2", data_2_o, 64'd0);
    check("rst/busy", 64'(busy_o), 64'd0);
    req_valid_i = 1'b1;
    #1;
    check("idle/busy_req", 64'(busy_o), 64'd1);
    flush_i = 1'b1;
    #1;
    check("idle/busy_flush", 64'(busy_o), 64'd0);
    req_valid_i = 1'b0;
    flush_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    run_op("mul", 1, 1, 1, 0, 64'd7, -64'sd3);
    run_op("mulhu", 1, 0, 0, 0, '1, '1);
    run_op("div", 0, 1, 1, 0, -64'sd7, 64'd2);
    run_op("div0", 0, 1, 1, 0, 64'd5, 64'd0);
    run_op("divovf", 0, 1, 1, 0,
           64'h8000_0000_0000_0000, '1);
    run_op("divw", 0, 1, 1, 1,
           64'h0000_0000_8000_0000, 64'd1);
    run_op("divwovf", 0, 1, 1, 1,
           64'h0000_0000_8000_0000, '1);
    run_op("divuw0", 0, 0, 0, 1,
           64'h1234_5678_9abc_def0, 64'hffff_ffff_0000_0000);
    run_op("mulw", 1, 1, 1, 1,
           64'h0000_0000_7fff_ffff, 64'h0000_0000_7fff_ffff);
    run_op("mulhsu", 1, 1, 0, 0, -64'sd5, '1);
    run_op("remu", 0, 0, 0, 0, 64'd1000, 64'd7);

    for (int i = 0; i < 16; i++) begin
      run_op($sformatf("rnd%0d", i),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             pick(int'($urandom_range(0, 8))),
             pick(int'($urandom_range(0, 8))));
    end

    // Flush while iterating.
    p1 = data_1_o;
    p2 = data_2_o;
    req_valid_i = 1'b1;
    mul_en_i    = 1'b0;
    rs1_sign_i  = 1'b1;
    rs2_sign_i  = 1'b1;
    word_i      = 1'b0;
    rs1_data_i  = 64'd100;
    rs2_data_i  = 64'd7;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      check("flush/no_resp", 64'(resp_valid_o), 64'd0);
    end
    flush_i = 1'b1;
    #1;
    check("flush/resp_n10", 64'(resp_valid_o), 64'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    #1;
    check("flush/idle", 64'(busy_o), 64'd0);
    check("flush/resp_n11", 64'(resp_valid_o), 64'd0);
    check("flush/hold_1", data_1_o, p1);
    check("flush/hold_2", data_2_o, p2);
    run_op("after_flush", 1, 0, 0, 0, 64'd3, 64'd5);

    // Asynchronous reset while iterating.
    req_valid_i = 1'b1;
    mul_en_i    = 1'b1;
    word_i      = 1'b0;
    rs1_data_i  = 64'd9;
    rs2_data_i  = 64'd9;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("arst/data_1", data_1_o, 64'd0);
    check("arst/data_2", data_2_o, 64'd0);
    check("arst/resp", 64'(resp_valid_o), 64'd0);
    req_valid_i = 1'b0;
    #1;
    check("arst/busy", 64'(busy_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk); #1;
      if (resp_valid_o) seen = 1'b1;
    end
    check("arst/no_resp", 64'(seen), 64'd0);
    check("arst/busy_after", 64'(busy_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for RV64M, sitting beside the execute stage. Execute drives it combinationally each cycle with forwarded operands, sign flags, op select and request-valid; the unit stalls the pipeline via `busy_o` while iterating. Results return on `data_1_o`/`data_2_o`, which execute muxes into its writeback data.

## Interface
- `DATA_W`, 64: operand/result width; word mode operates on `DATA_W/2`.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  1  M-extension op present in execute; held high while stalled.
- `mul_en_i`  in  1  1 = multiply, 0 = divide/remainder.
- `rs1_sign_i`  in  1  1 = treat rs1 as signed.
- `rs2_sign_i`  in  1  1 = treat rs2 as signed.
- `word_i`  in  1  1 = *W op (low 32 bits, sign-extended results).
- `rs1_data_i`  in  DATA_W  multiplicand/dividend, already forwarded.
- `rs2_data_i`  in  DATA_W  multiplier/divisor, already forwarded.
- `flush_i`  in  1  branch/jump kill of the instruction in execute.
- `busy_o`  out  1  stall request to the pipeline.
- `resp_valid_o`  out  1  one-cycle pulse: results valid.
- `data_1_o`  out  DATA_W  product low / quotient.
- `data_2_o`  out  DATA_W  product high / remainder.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: accept when `req_valid_i & ~flush_i`. Latch magnitudes of operands, result sign flags, op and word mode; load iteration counter; go to BUSY. Divide with zero divisor goes directly to DONE instead.
- BUSY: one bit per cycle (shift-add multiply, restoring divide). Go to DONE after the iteration with counter == 0.
- DONE: apply sign fix-ups and register outputs. Pulse `resp_valid_o`, then return to IDLE. `req_valid_i` seen in DONE belongs to the completing instruction and is ignored.
- `busy_o = (state==BUSY) | (state==IDLE & req_valid_i & ~flush_i)`. It is 0 in DONE, so the pipeline advances at the end of the DONE cycle.
- `flush_i` in any state: next state IDLE, no `resp_valid_o`, data outputs unchanged. Flush has priority over accept.
- Operand signing:
  - An operand is negative iff its sign flag is set and its MSB is set. In word mode the MSB is bit 31.
  - Magnitude = two's-complement negation if negative, otherwise the value unchanged.
- Multiply:
  - Unsigned 2·DATA_W product of the magnitudes, negated if exactly one operand is negative.
  - `data_1_o` = low half, `data_2_o` = high half.
  - Word mode: `data_1_o` = sext(product[31:0]), `data_2_o` = sext(product[63:32]).
- Divide:
  - Quotient is negated if exactly one operand is negative; remainder takes the dividend's sign.
  - Divisor 0: quotient = all ones, remainder = dividend (sext in word mode).
  - Signed overflow (most-negative ÷ −1) produces quotient = dividend, remainder = 0 without special-casing. The bench checks it.
  - Word mode: both results sext from bit 31.
- Data outputs hold the last result until the next DONE.
- Reset: state IDLE, `resp_valid_o` 0, `data_1_o`/`data_2_o` 0. `busy_o` is 0 unless `req_valid_i` is high.

## Timing
- Accept in cycle N: BUSY for cycles N+1 .. N+K, DONE and `resp_valid_o` in N+K+1. Next accept is possible in N+K+2.
- K = 64 for all ops (see Configuration). Divide-by-zero: DONE in N+1.
- `busy_o` is combinational from `req_valid_i`/`flush_i` in IDLE; registered-state-only otherwise.
- Reset mid-BUSY aborts immediately (asynchronous); no response is produced.

## Configuration
- `MULDIV_WORD_FAST_EN` defined: word ops iterate K = 32; 64-bit ops K = 64.
- Not defined: all ops iterate K = 64. Word operands are sign/zero-extended to 64 bits first, and results are identical.

## Test plan
- MUL: rs1 = 7, rs2 = −3 signed/signed. Expect `resp_valid_o` at N+65, `data_1_o` = 0xFFFF_FFFF_FFFF_FFEB, `data_2_o` = all ones. `busy_o` high N .. N+64.
- MULHU: rs1 = rs2 = 0xFFFF_FFFF_FFFF_FFFF unsigned. Expect `data_2_o` = 0xFFFF_FFFF_FFFF_FFFE, `data_1_o` = 1.
- DIV: rs1 = −7, rs2 = 2 signed. Expect quotient −3, remainder −1. DIV by 0: rs1 = 5. Expect DONE at N+1, quotient all ones, remainder 5.
- DIV overflow: rs1 = 0x8000_0000_0000_0000, rs2 = −1. Expect quotient 0x8000_0000_0000_0000, remainder 0.
- DIVW: rs1 = 0x0000_0000_8000_0000, rs2 = 1 signed. Expect `data_1_o` = 0xFFFF_FFFF_8000_0000. Latency N+33 with `MULDIV_WORD_FAST_EN`, N+65 without.
- Flush in BUSY at N+10: expect IDLE at N+11, no `resp_valid_o`, outputs unchanged. A new request at N+11 is accepted. Also assert `rst` low mid-BUSY: outputs zero immediately.
